// File: rtl/tile_color_mapper.sv
// rtl/tile_color_mapper.sv - two-stage pixel colour generator: tiles over a gradient background, with hit flash and miss tint.
// The optional lane-divider overlay is enabled by defining LANE_DIVIDER_EN.
module tile_color_mapper #(
  parameter int NUM_TILES    = 4,
  parameter int COORD_W      = 10,
  parameter int HALF_W       = 40,
  parameter int HALF_H       = 30,
  parameter int FLASH_FRAMES = 8,
  parameter int MISS_FRAMES  = 16,
  parameter int LANE_W_LOG2  = 7
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_start,
  input  logic                         pixel_valid_in,
  input  logic [COORD_W-1:0]           DrawX,
  input  logic [COORD_W-1:0]           DrawY,
  input  logic [NUM_TILES*COORD_W-1:0] TileX,
  input  logic [NUM_TILES*COORD_W-1:0] TileY,
  input  logic [NUM_TILES-1:0]         tile_valid,
  input  logic [NUM_TILES-1:0]         hit_pulse,
  input  logic                         miss_pulse,
  output logic                         pixel_valid_out,
  output logic [7:0]                   Red,
  output logic [7:0]                   Green,
  output logic [7:0]                   Blue
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W:0] HW = CW1'(HALF_W);
  localparam logic [COORD_W:0] HH = CW1'(HALF_H);
`ifdef LANE_DIVIDER_EN
  localparam int DX_W = COORD_W;
`else
  localparam int DX_W = 6;
`endif

  // Elaboration-time guard against out-of-range parameters.
  if (COORD_W < 6 || FLASH_FRAMES < 1 || FLASH_FRAMES > 255 ||
      MISS_FRAMES < 1 || MISS_FRAMES > 255 ||
      LANE_W_LOG2 < 1 || LANE_W_LOG2 > COORD_W) begin : g_bad_params
    $error("tile_color_mapper: illegal parameter value");
  end

  logic [COORD_W-1:0] r_tile_x     [NUM_TILES];
  logic [COORD_W-1:0] r_tile_y     [NUM_TILES];
  logic [NUM_TILES-1:0] r_tile_valid;
  logic [7:0]         r_flash      [NUM_TILES];
  logic [7:0]         r_miss_cnt;

  logic [NUM_TILES-1:0] w_inside;
  logic [NUM_TILES-1:0] w_flash_nz;

  logic [NUM_TILES-1:0] r_s1_hit;
  logic [NUM_TILES-1:0] r_s1_flash;
  logic [DX_W-1:0]      r_s1_drawx;
  logic                 r_s1_miss;
  logic                 r_s1_valid;

  logic                 w_sel_flash;
  logic [5:0]           w_drawx_hi;
  logic [7:0]           w_red;
  logic [7:0]           w_green;
  logic [7:0]           w_blue;

  // Tile positions only change on frame_start so a tile never tears mid-frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_tile_valid <= '0;
      for (int i = 0; i < NUM_TILES; i++) begin
        r_tile_x[i] <= '0;
        r_tile_y[i] <= '0;
      end
    end else if (frame_start) begin
      r_tile_valid <= tile_valid;
      for (int i = 0; i < NUM_TILES; i++) begin
        r_tile_x[i] <= TileX[i*COORD_W +: COORD_W];
        r_tile_y[i] <= TileY[i*COORD_W +: COORD_W];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_miss_cnt <= '0;
    end else if (miss_pulse) begin
      r_miss_cnt <= MISS_FRAMES[7:0];
    end else if (frame_start && r_miss_cnt != 8'd0) begin
      r_miss_cnt <= r_miss_cnt - 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_TILES; g++) begin : g_tile
    logic [COORD_W:0] w_tx;
    logic [COORD_W:0] w_ty;
    logic [COORD_W:0] w_left;
    logic [COORD_W:0] w_right;
    logic [COORD_W:0] w_top;
    logic [COORD_W:0] w_bottom;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        r_flash[g] <= '0;
      end else if (hit_pulse[g]) begin
        r_flash[g] <= FLASH_FRAMES[7:0];
      end else if (frame_start && r_flash[g] != 8'd0) begin
        r_flash[g] <= r_flash[g] - 8'd1;
      end
    end

    // One extra bit keeps the edges from wrapping near 0 and the screen limit.
    assign w_tx     = {1'b0, r_tile_x[g]};
    assign w_ty     = {1'b0, r_tile_y[g]};
    assign w_left   = (w_tx >= HW) ? (w_tx - HW) : '0;
    assign w_right  = w_tx + HW;
    assign w_top    = (w_ty >= HH) ? (w_ty - HH) : '0;
    assign w_bottom = w_ty + HH;

    assign w_inside[g] = r_tile_valid[g] &&
                         ({1'b0, DrawX} >= w_left) && ({1'b0, DrawX} <= w_right) &&
                         ({1'b0, DrawY} >= w_top)  && ({1'b0, DrawY} <= w_bottom);
    assign w_flash_nz[g] = (r_flash[g] != 8'd0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_hit   <= '0;
      r_s1_flash <= '0;
      r_s1_drawx <= '0;
      r_s1_miss  <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_hit   <= w_inside;
      r_s1_flash <= w_flash_nz;
      r_s1_drawx <= DrawX[COORD_W-1 -: DX_W];
      r_s1_miss  <= (r_miss_cnt != 8'd0);
      r_s1_valid <= pixel_valid_in;
    end
  end

  // Scanning from the top index down lets the lowest hit tile overwrite last.
  always_comb begin
    w_sel_flash = 1'b0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) begin
        w_sel_flash = r_s1_flash[i];
      end
    end
  end

  assign w_drawx_hi = r_s1_drawx[DX_W-1 -: 6];

  always_comb begin
    w_red   = r_s1_miss ? 8'h60 : 8'h00;
    w_green = 8'h00;
    w_blue  = 8'h7F - {2'b00, w_drawx_hi};
`ifdef LANE_DIVIDER_EN
    if (r_s1_drawx[LANE_W_LOG2-1:0] == '0 && r_s1_drawx != '0) begin
      w_red   = 8'h40;
      w_green = 8'h40;
      w_blue  = 8'h40;
    end
`endif
    if (|r_s1_hit) begin
      w_red   = w_sel_flash ? 8'hA0 : 8'hFF;
      w_green = w_sel_flash ? 8'hA0 : 8'hFF;
      w_blue  = w_sel_flash ? 8'hA0 : 8'hFF;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Red             <= '0;
      Green           <= '0;
      Blue            <= '0;
      pixel_valid_out <= 1'b0;
    end else begin
      Red             <= w_red;
      Green           <= w_green;
      Blue            <= w_blue;
      pixel_valid_out <= r_s1_valid;
    end
  end

endmodule

// File: tb/tb_tile_color_mapper.sv
// tb/tb_tile_color_mapper.sv - directed and randomized checks of tile_color_mapper against a frame-level model.
module tb_tile_color_mapper;
  localparam int NT = 4;
  localparam int CW = 10;
  localparam int HW = 40;
  localparam int HH = 30;
  localparam int FF_N = 8;
  localparam int MF_N = 16;
  localparam int LW = 7;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             frame_start = 1'b0;
  logic             pixel_valid_in = 1'b0;
  logic [CW-1:0]    DrawX = '0;
  logic [CW-1:0]    DrawY = '0;
  logic [NT*CW-1:0] TileX = '0;
  logic [NT*CW-1:0] TileY = '0;
  logic [NT-1:0]    tile_valid = '0;
  logic [NT-1:0]    hit_pulse = '0;
  logic             miss_pulse = 1'b0;
  logic             pixel_valid_out;
  logic [7:0]       Red, Green, Blue;

  int tests = 0;
  int fails = 0;

  int in_tx [NT];
  int in_ty [NT];
  int in_v  [NT];
  int m_tx  [NT];
  int m_ty  [NT];
  int m_v   [NT];
  int m_flash [NT];
  int m_miss;

  tile_color_mapper #(
    .NUM_TILES(NT), .COORD_W(CW), .HALF_W(HW), .HALF_H(HH),
    .FLASH_FRAMES(FF_N), .MISS_FRAMES(MF_N), .LANE_W_LOG2(LW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .pixel_valid_in(pixel_valid_in), .DrawX(DrawX), .DrawY(DrawY),
    .TileX(TileX), .TileY(TileY), .tile_valid(tile_valid),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .pixel_valid_out(pixel_valid_out), .Red(Red), .Green(Green), .Blue(Blue)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] model_color(input int x, input int y);
    for (int i = 0; i < NT; i++) begin
      int l, r, t, b;
      l = m_tx[i] - HW; if (l < 0) l = 0;
      r = m_tx[i] + HW;
      t = m_ty[i] - HH; if (t < 0) t = 0;
      b = m_ty[i] + HH;
      if (m_v[i] != 0 && x >= l && x <= r && y >= t && y <= b)
        return (m_flash[i] != 0) ? 24'hA0A0A0 : 24'hFFFFFF;
    end
`ifdef LANE_DIVIDER_EN
    if ((x % (1 << LW)) == 0 && x != 0) return 24'h404040;
`endif
    return {(m_miss != 0) ? 8'h60 : 8'h00, 8'h00, 8'(127 - x / (1 << (CW - 6)))};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NT; i++) begin
      m_tx[i] = 0; m_ty[i] = 0; m_v[i] = 0; m_flash[i] = 0;
    end
    m_miss = 0;
  endtask

  task automatic set_tile(input int i, input int x, input int y, input int v);
    in_tx[i] = x; in_ty[i] = y; in_v[i] = v;
    TileX[i*CW +: CW] = CW'(x);
    TileY[i*CW +: CW] = CW'(y);
    tile_valid[i] = (v != 0);
  endtask

  task automatic pulse(input logic fs, input logic [NT-1:0] hit, input logic miss);
    @(negedge Clk);
    frame_start = fs; hit_pulse = hit; miss_pulse = miss;
    @(posedge Clk);
    for (int i = 0; i < NT; i++) begin
      if (fs) begin m_tx[i] = in_tx[i]; m_ty[i] = in_ty[i]; m_v[i] = in_v[i]; end
      if (hit[i]) m_flash[i] = FF_N;
      else if (fs && m_flash[i] > 0) m_flash[i]--;
    end
    if (miss) m_miss = MF_N;
    else if (fs && m_miss > 0) m_miss--;
    @(negedge Clk);
    frame_start = 1'b0; hit_pulse = '0; miss_pulse = 1'b0;
  endtask

  task automatic px(input string tag, input int x, input int y, input logic [23:0] exp);
    @(negedge Clk);
    DrawX = CW'(x); DrawY = CW'(y); pixel_valid_in = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk(tag, {8'h00, Red, Green, Blue}, {8'h00, exp});
    chk({tag, "_pv"}, {31'd0, pixel_valid_out}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    model_clear();
    chk("reset_rgb", {8'h00, Red, Green, Blue}, 32'd0);
    chk("reset_pv", {31'd0, pixel_valid_out}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    int x, y, t, r;
    for (int i = 0; i < NT; i++) set_tile(i, 0, 0, 0);
    model_clear();
    repeat (2) @(posedge Clk);
    do_reset();

    set_tile(0, 100, 100, 1);
    pulse(1'b1, '0, 1'b0);
    px("t0_centre", 100, 100, 24'hFFFFFF);
    px("t0_right_out", 141, 100, 24'h000077);

    set_tile(0, 300, 100, 1);
    px("no_latch_midframe", 100, 100, 24'hFFFFFF);
    pulse(1'b1, '0, 1'b0);
    px("latched_new", 300, 100, 24'hFFFFFF);
    px("old_pos_bg", 100, 100, 24'h000079);

    set_tile(0, 10, 100, 1);
    pulse(1'b1, '0, 1'b0);
    px("left_clamp", 0, 100, 24'hFFFFFF);
    px("no_wrap", 1023, 100, 24'h000040);
    px("right_edge", 50, 100, 24'hFFFFFF);
    px("right_edge_out", 51, 100, 24'h00007C);
    px("top_edge", 10, 70, 24'hFFFFFF);
    px("top_edge_out", 10, 69, 24'h00007F);

    set_tile(0, 200, 200, 1);
    set_tile(2, 250, 200, 1);
    pulse(1'b1, '0, 1'b0);
    pulse(1'b0, 4'b0100, 1'b0);
    px("overlap_prio", 220, 200, 24'hFFFFFF);
    px("t2_flash", 280, 200, 24'hA0A0A0);
    for (int k = 1; k <= FF_N; k++) begin
      pulse(1'b1, '0, 1'b0);
      px("t2_flash_frames", 280, 200, (k < FF_N) ? 24'hA0A0A0 : 24'hFFFFFF);
    end

    set_tile(1, 500, 400, 1);
    pulse(1'b1, 4'b0010, 1'b0);
    px("hit_fs_same", 500, 400, 24'hA0A0A0);
    repeat (FF_N - 1) pulse(1'b1, '0, 1'b0);
    px("hit_fs_last", 500, 400, 24'hA0A0A0);
    pulse(1'b1, '0, 1'b0);
    px("hit_fs_done", 500, 400, 24'hFFFFFF);

    pulse(1'b0, '0, 1'b1);
    px("miss_tint", 600, 50, 24'h60005A);
    for (int k = 1; k <= MF_N; k++) begin
      pulse(1'b1, '0, 1'b0);
      px("miss_frames", 600, 50, (k < MF_N) ? 24'h60005A : 24'h00005A);
    end

`ifdef LANE_DIVIDER_EN
    px("lane_div", 128, 5, 24'h404040);
    px("lane_div_zero", 0, 5, 24'h00007F);
`else
    px("no_lane_div", 128, 5, 24'h000077);
`endif

    @(negedge Clk);
    DrawX = 10'd200; DrawY = 10'd200; pixel_valid_in = 1'b1;
    @(posedge Clk);
    do_reset();
    px("post_reset_no_tile", 200, 200, 24'h000073);

    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        for (int i = 0; i < NT; i++)
          set_tile(i, $urandom_range(0, 1023), $urandom_range(0, 767), $urandom_range(0, 3) != 0);
        pulse(1'b1, NT'($urandom_range(0, 15)), $urandom_range(0, 5) == 0);
      end else if (r < 4) begin
        pulse($urandom_range(0, 1) == 1, NT'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
      end else begin
        t = $urandom_range(0, NT - 1);
        x = m_tx[t] + $urandom_range(0, 100) - 50;
        y = m_ty[t] + $urandom_range(0, 80) - 40;
        if ($urandom_range(0, 4) == 0) x = $urandom_range(0, 1023);
        if (x < 0) x = 0;
        if (x > 1023) x = 1023;
        if (y < 0) y = 0;
        if (y > 1023) y = 1023;
        px("random", x, y, model_color(x, y));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tile_color_mapper.md
Name: tile_color_mapper

Overview:
- Pipelined, parametrised pixel colour generator for the piano-tile display. Draws up to NUM_TILES rectangular tiles over a gradient background.
- Tile positions are latched once per frame, so a tile never tears mid-frame.
- A hit-flash timer per tile and a screen-wide miss tint give visual feedback.
- Sits between the VGA controller (DrawX/DrawY) and the VGA DAC outputs. Tile positions come from the game logic.

Parameters:
- NUM_TILES, 4, number of tile slots drawn.
- COORD_W, 10, width of every X/Y coordinate; must be >= 6.
- HALF_W, 40, tile half-width in pixels.
- HALF_H, 30, tile half-height in pixels.
- FLASH_FRAMES, 8, frames a tile shows the flash colour after a hit; range 1..255.
- MISS_FRAMES, 16, frames the background shows the red tint after a miss; range 1..255.
- LANE_W_LOG2, 7, log2 of lane width; used only by LANE_DIVIDER_EN.

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse, once per frame, during vertical blank.
- pixel_valid_in  in  1  DrawX/DrawY valid this cycle.
- DrawX  in  COORD_W  current pixel column.
- DrawY  in  COORD_W  current pixel row.
- TileX  in  NUM_TILES*COORD_W  tile centre X; tile i occupies bits [i*COORD_W +: COORD_W].
- TileY  in  NUM_TILES*COORD_W  tile centre Y; same packing as TileX.
- tile_valid  in  NUM_TILES  tile i is live.
- hit_pulse  in  NUM_TILES  one-cycle pulse: tile i was hit.
- miss_pulse  in  1  one-cycle pulse: the player missed.
- pixel_valid_out  out  1  pixel_valid_in delayed by 2 cycles.
- Red  out  8  pixel colour, red channel.
- Green  out  8  pixel colour, green channel.
- Blue  out  8  pixel colour, blue channel.

Behaviour:
- Reset is synchronous and active-high on Clk.
- Reset values:
  - Red/Green/Blue = 0, pixel_valid_out = 0.
  - All shadow registers = 0, including shadow tile_valid.
  - All flash counters = 0, miss counter = 0.
- Frame latch: when frame_start = 1, shadow TileX/TileY/tile_valid <= inputs. Between pulses the shadow copies hold.
- Flash counter per tile, 8 bits:
  - hit_pulse[i] loads FLASH_FRAMES.
  - Otherwise frame_start decrements it while non-zero, saturating at 0.
  - hit_pulse and frame_start in the same cycle: load wins.
- Miss counter: identical rules, using miss_pulse and MISS_FRAMES.
- Bounds per tile, computed in COORD_W+1 bits with no wrap:
  - left = max(TileX - HALF_W, 0); right = TileX + HALF_W.
  - top = max(TileY - HALF_H, 0); bottom = TileY + HALF_H.
  - Inside means left <= DrawX <= right and top <= DrawY <= bottom (unsigned compare).
- Pipeline, latency exactly 2 cycles from DrawX/DrawY/pixel_valid_in to outputs:
  - Stage 1 registers: the hit mask (inside AND shadow valid, per tile), DrawX, the any-flash mask, the miss-active flag, pixel_valid.
  - Stage 2 registers: the RGB outputs.
  - No stall. Outputs update every cycle.
- Colour priority in stage 2:
  1. Hit mask non-zero: the lowest-index tile wins. Its colour is FF/FF/FF, or A0/A0/A0 if its flash counter is non-zero.
  2. Otherwise, background:
     - Red = 00, Green = 00.
     - Blue = 7F - zero-extended DrawX[COORD_W-1 : COORD_W-6].
     - If the miss counter is non-zero, Red = 60 instead.
- pixel_valid_in = 0: the colour path still computes; the outputs are a don't-care for the sink, but still deterministic.
- Reset asserted mid-frame: every register clears on the next edge, and pixel_valid_out goes low. No tiles are drawn until the first frame_start after reset is deasserted.
- DrawX/DrawY beyond the screen: no special handling; the normal compare applies.

Optional Feature:
- Macro: LANE_DIVIDER_EN.
- Defined: a background pixel with DrawX[LANE_W_LOG2-1:0] == 0 and DrawX != 0 outputs 40/40/40.
  - Ranks above the gradient and the miss tint.
  - Ranks below tiles.
  - Latency unchanged.
- Undefined: no divider logic is synthesised, and the background is as described above.

Test Plan:
- Reset, then frame_start with TileX0 = 100, TileY0 = 100, valid0 = 1. Scan pixel (100,100) -> FFFFFF 2 cycles later. Pixel (141,100) -> background, Blue = 7F - 08 = 77.
- Change TileX0 to 300 mid-frame without frame_start: (100,100) stays FFFFFF. Pulse frame_start: (300,100) -> FFFFFF and (100,100) -> background.
- TileX0 = 10, HALF_W = 40: left clamps to 0. Pixel (1023,100) -> background, proving no wrap-around.
- Tiles 0 and 2 overlap. Pulse hit_pulse[2]: the overlap shows tile 0's colour (FFFFFF). The tile-2-only region shows A0A0A0 for exactly 8 frame_start pulses, then FFFFFF.
- Assert hit_pulse[1] and frame_start in the same cycle -> counter = FLASH_FRAMES. Send miss_pulse: background Red = 60 for 16 frames, then 00.
- With LANE_DIVIDER_EN defined: pixel (128,5) with no tile -> 404040. Pixel (0,5) -> gradient background.
